// File: rtl/rv32_data_mem_responder_if.sv
// Data-memory request/response bundle between the load/store unit (master)
// and the memory responder (slave).
interface rv32_data_mem_responder_if;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_write;
  logic [3:0]  req_strobe;
  logic [31:0] req_wdata;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_error;

  modport master (
    output req_valid, req_addr, req_write, req_strobe, req_wdata,
    input  resp_ready, resp_data, resp_error
  );

  modport slave (
    input  req_valid, req_addr, req_write, req_strobe, req_wdata,
    output resp_ready, resp_data, resp_error
  );
endinterface

// File: rtl/rv32_data_mem_responder.sv
// Word-organised data RAM responder with a fixed number of wait states
// between request acceptance and a single-cycle registered response.
//
// state | meaning
// IDLE  | waiting for req_valid; request captured on acceptance
// WAIT  | counting down LATENCY wait states
// DONE  | resp_* valid for this cycle; store commits on the closing edge
module rv32_data_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned LATENCY     = 0
) (
  input  logic                            clk,
  input  logic                            resetn,
  rv32_data_mem_responder_if.slave        bus_if
);
  localparam int unsigned AW   = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LAT4 = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        write_q, write_d;
  logic [3:0]  strobe_q, strobe_d;
  logic [31:0] wdata_q, wdata_d;
  logic        resp_ready_q, resp_ready_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_error_q, resp_error_d;

  logic [31:0] mem [DEPTH_WORDS];

  // With LATENCY=0 the response is formed on the acceptance edge, so the
  // access view comes straight from the bus while idle, otherwise from the
  // captured copy.
  logic [31:0]   acc_addr;
  logic          acc_write;
  logic [3:0]    acc_strobe;
  logic [29:0]   acc_word;
  logic [AW-1:0] acc_idx;
  logic          acc_err;
  logic          wr_en;

  function automatic logic strobe_legal(input logic [3:0] s);
    case (s)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

  always_comb begin
    acc_addr   = addr_q;
    acc_write  = write_q;
    acc_strobe = strobe_q;
    if (state_q == IDLE) begin
      acc_addr   = bus_if.req_addr;
      acc_write  = bus_if.req_write;
      acc_strobe = bus_if.req_strobe;
    end
    acc_word = 30'((acc_addr - BASE_ADDR) >> 2);
    acc_idx  = acc_word[AW-1:0];
    acc_err  = (acc_addr < BASE_ADDR)
             || ({2'b00, acc_word} >= 32'(DEPTH_WORDS))
             || !strobe_legal(acc_strobe);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      write_q      <= 1'b0;
      strobe_q     <= '0;
      wdata_q      <= '0;
      resp_ready_q <= 1'b0;
      resp_data_q  <= '0;
      resp_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      write_q      <= write_d;
      strobe_q     <= strobe_d;
      wdata_q      <= wdata_d;
      resp_ready_q <= resp_ready_d;
      resp_data_q  <= resp_data_d;
      resp_error_q <= resp_error_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    write_d      = write_q;
    strobe_d     = strobe_q;
    wdata_d      = wdata_q;
    resp_ready_d = 1'b0;
    resp_data_d  = '0;
    resp_error_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus_if.req_valid) begin
          addr_d   = bus_if.req_addr;
          write_d  = bus_if.req_write;
          strobe_d = bus_if.req_strobe;
          wdata_d  = bus_if.req_wdata;
          cnt_d    = LAT4;
          state_d  = (LAT4 == 4'd0) ? DONE : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Response registers load on the edge that enters DONE; a store made on
    // an earlier DONE edge is already visible to this read.
    if (state_d == DONE) begin
      resp_ready_d = 1'b1;
      resp_error_d = acc_err;
      if (!acc_err && !acc_write) resp_data_d = mem[acc_idx];
    end
  end

  assign wr_en = (state_q == DONE) && write_q && !acc_err;

  always_ff @(posedge clk) begin
    if (resetn && wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (strobe_q[b]) mem[acc_idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign bus_if.resp_ready = resp_ready_q;
  assign bus_if.resp_data  = resp_data_q;
  assign bus_if.resp_error = resp_error_q;
endmodule

// File: tb/tb_rv32_data_mem_responder.sv
// Self-checking bench: three responders (LATENCY 0/2/3) driven from one
// shared request source, responses checked against a scoreboard queue.
module tb_rv32_data_mem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rstn;
  int         sel;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_write;
  logic [3:0]  req_strobe;
  logic [31:0] req_wdata;

  rv32_data_mem_responder_if if_l0 ();
  rv32_data_mem_responder_if if_l2 ();
  rv32_data_mem_responder_if if_l3 ();

  rv32_data_mem_responder #(.LATENCY(0)) u_l0 (
    .clk(clk), .resetn(rstn[0]), .bus_if(if_l0));
  rv32_data_mem_responder #(.LATENCY(2), .DEPTH_WORDS(256)) u_l2 (
    .clk(clk), .resetn(rstn[1]), .bus_if(if_l2));
  rv32_data_mem_responder #(.LATENCY(3), .DEPTH_WORDS(256)) u_l3 (
    .clk(clk), .resetn(rstn[2]), .bus_if(if_l3));

  assign if_l0.req_valid  = req_valid && (sel == 0);
  assign if_l2.req_valid  = req_valid && (sel == 1);
  assign if_l3.req_valid  = req_valid && (sel == 2);
  assign if_l0.req_addr   = req_addr;
  assign if_l2.req_addr   = req_addr;
  assign if_l3.req_addr   = req_addr;
  assign if_l0.req_write  = req_write;
  assign if_l2.req_write  = req_write;
  assign if_l3.req_write  = req_write;
  assign if_l0.req_strobe = req_strobe;
  assign if_l2.req_strobe = req_strobe;
  assign if_l3.req_strobe = req_strobe;
  assign if_l0.req_wdata  = req_wdata;
  assign if_l2.req_wdata  = req_wdata;
  assign if_l3.req_wdata  = req_wdata;

  logic        m_ready;
  logic [31:0] m_data;
  logic        m_error;
  always_comb begin
    m_ready = if_l0.resp_ready;
    m_data  = if_l0.resp_data;
    m_error = if_l0.resp_error;
    if (sel == 1) begin
      m_ready = if_l2.resp_ready;
      m_data  = if_l2.resp_data;
      m_error = if_l2.resp_error;
    end else if (sel == 2) begin
      m_ready = if_l3.resp_ready;
      m_data  = if_l3.resp_data;
      m_error = if_l3.resp_error;
    end
  end

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] wd;
    logic [31:0] ed;
    logic        ee;
  } vec_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en && m_ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL spurious_resp: got resp_ready=1 (data %h), expected no response", m_data);
      end else begin
        e = sb_q.pop_front();
        check("resp_data", m_data, e.data);
        check("resp_error", {31'b0, m_error}, {31'b0, e.err});
      end
    end
  end

  function automatic int lat_of(input int s);
    return (s == 0) ? 0 : (s == 1) ? 2 : 3;
  endfunction

  task automatic wait_resp(input string name, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_ready && n < 40);
    if (!m_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got no resp_ready in %0d cycles, expected a response", name, n);
      void'(sb_q.pop_back());
    end
  endtask

  task automatic run_op(input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] wd, input logic [31:0] ed, input logic ee,
                        input string name);
    int   n;
    exp_t e;
    @(negedge clk);
    req_write  = w;
    req_addr   = a;
    req_strobe = s;
    req_wdata  = wd;
    req_valid  = 1'b1;
    e.data = ed;
    e.err  = ee;
    sb_q.push_back(e);
    wait_resp(name, n);
    req_valid = 1'b0;
    if (m_ready) check({name, "_latency"}, 32'(n), 32'(lat_of(sel) + 1));
  endtask

  vec_t vt[22];

  initial begin
    int   n;
    exp_t e;

    vt[0]  = '{1'b1, 32'h10,   4'b1111, 32'hDEADBEEF, 32'h0,        1'b0};
    vt[1]  = '{1'b0, 32'h10,   4'b1111, 32'h0,        32'hDEADBEEF, 1'b0};
    vt[2]  = '{1'b1, 32'h10,   4'b0100, 32'h00AA0000, 32'h0,        1'b0};
    vt[3]  = '{1'b0, 32'h10,   4'b1111, 32'h0,        32'hDEAABEEF, 1'b0};
    vt[4]  = '{1'b1, 32'h30,   4'b1111, 32'hCAFEF00D, 32'h0,        1'b0};
    vt[5]  = '{1'b1, 32'h30,   4'b0110, 32'hFFFFFFFF, 32'h0,        1'b1};
    vt[6]  = '{1'b0, 32'h30,   4'b0001, 32'h0,        32'hCAFEF00D, 1'b0};
    vt[7]  = '{1'b0, 32'h4000, 4'b1111, 32'h0,        32'h0,        1'b1};
    vt[8]  = '{1'b1, 32'h3FFC, 4'b1111, 32'h11112222, 32'h0,        1'b0};
    vt[9]  = '{1'b1, 32'h3FFC, 4'b0011, 32'h0000ABCD, 32'h0,        1'b0};
    vt[10] = '{1'b0, 32'h3FFC, 4'b0010, 32'h0,        32'h1111ABCD, 1'b0};
    vt[11] = '{1'b0, 32'h13,   4'b1000, 32'h0,        32'hDEAABEEF, 1'b0};
    vt[12] = '{1'b0, 32'h10,   4'b0000, 32'h0,        32'h0,        1'b1};
    vt[13] = '{1'b1, 32'h30,   4'b1100, 32'hAAAA0000, 32'h0,        1'b0};
    vt[14] = '{1'b0, 32'h30,   4'b1111, 32'h0,        32'hAAAAF00D, 1'b0};
    vt[15] = '{1'b0, 32'h30,   4'b0101, 32'h0,        32'h0,        1'b1};
    vt[16] = '{1'b1, 32'h10,   4'b1000, 32'h77000000, 32'h0,        1'b0};
    vt[17] = '{1'b0, 32'h10,   4'b1111, 32'h0,        32'h77AABEEF, 1'b0};
    vt[18] = '{1'b1, 32'h4010, 4'b1111, 32'h00000055, 32'h0,        1'b1};
    vt[19] = '{1'b0, 32'h10,   4'b1111, 32'h0,        32'h77AABEEF, 1'b0};
    vt[20] = '{1'b1, 32'h10,   4'b0000, 32'h12345678, 32'h0,        1'b1};
    vt[21] = '{1'b0, 32'h10,   4'b1111, 32'h0,        32'h77AABEEF, 1'b0};

    rstn       = 3'b000;
    sel        = 0;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_write  = 1'b0;
    req_strobe = '0;
    req_wdata  = '0;
    repeat (3) @(negedge clk);
    check("rst_ready_l0", {31'b0, if_l0.resp_ready}, 32'h0);
    check("rst_data_l0",  if_l0.resp_data, 32'h0);
    check("rst_error_l0", {31'b0, if_l0.resp_error}, 32'h0);
    check("rst_ready_l2", {31'b0, if_l2.resp_ready}, 32'h0);
    check("rst_ready_l3", {31'b0, if_l3.resp_ready}, 32'h0);
    rstn   = 3'b111;
    mon_en = 1'b1;

    for (int i = 0; i < 22; i++) begin
      run_op(vt[i].w, vt[i].a, vt[i].s, vt[i].wd, vt[i].ed, vt[i].ee, $sformatf("vec%0d", i));
    end

    // Continuous req_valid, alternating store/load: one response per 2 cycles.
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      req_write  = (i % 2 == 0);
      req_addr   = 32'h50;
      req_strobe = 4'b1111;
      req_wdata  = 32'h5000_0000 + 32'(i);
      req_valid  = 1'b1;
      e.data = (i % 2 == 0) ? 32'h0 : 32'h5000_0000 + 32'(i - 1);
      e.err  = 1'b0;
      sb_q.push_back(e);
      wait_resp($sformatf("b2b%0d", i), n);
      if (m_ready) check($sformatf("b2b%0d_interval", i), 32'(n), (i == 0) ? 32'd1 : 32'd2);
    end
    req_valid = 1'b0;
    @(negedge clk);

    // LATENCY=3: exact pulse position, address change during WAIT ignored.
    sel = 2;
    run_op(1'b1, 32'h20, 4'b1111, 32'h20202020, 32'h0, 1'b0, "l3_st20");
    run_op(1'b1, 32'h24, 4'b1111, 32'h24242424, 32'h0, 1'b0, "l3_st24");
    @(negedge clk);
    req_write  = 1'b0;
    req_addr   = 32'h20;
    req_strobe = 4'b1111;
    req_valid  = 1'b1;
    e.data = 32'h20202020;
    e.err  = 1'b0;
    sb_q.push_back(e);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) req_addr = 32'h24;
      check($sformatf("l3_ready_c%0d", k), {31'b0, m_ready}, (k == 4) ? 32'h1 : 32'h0);
      if (k == 4) req_valid = 1'b0;
    end

    // LATENCY=2: reset during WAIT and during DONE both drop the store.
    sel = 1;
    run_op(1'b1, 32'h40, 4'b1111, 32'hA5A5A5A5, 32'h0, 1'b0, "l2_st");
    run_op(1'b0, 32'h40, 4'b1111, 32'h0, 32'hA5A5A5A5, 1'b0, "l2_ld");
    @(negedge clk);
    req_write  = 1'b1;
    req_addr   = 32'h40;
    req_strobe = 4'b1111;
    req_wdata  = 32'h12345678;
    req_valid  = 1'b1;
    @(negedge clk);
    check("l2_wait_ready", {31'b0, m_ready}, 32'h0);
    rstn[1]   = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    rstn[1] = 1'b1;
    check("l2_post_rst_ready", {31'b0, m_ready}, 32'h0);
    check("l2_post_rst_data",  m_data, 32'h0);
    check("l2_post_rst_error", {31'b0, m_error}, 32'h0);
    @(negedge clk);
    check("l2_post_rst_ready2", {31'b0, m_ready}, 32'h0);
    run_op(1'b0, 32'h40, 4'b1111, 32'h0, 32'hA5A5A5A5, 1'b0, "l2_ld_after_wait_rst");

    @(negedge clk);
    req_write = 1'b1;
    req_wdata = 32'h0BADF00D;
    req_valid = 1'b1;
    e.data = 32'h0;
    e.err  = 1'b0;
    sb_q.push_back(e);
    wait_resp("l2_done_rst", n);
    req_valid = 1'b0;
    rstn[1]   = 1'b0;
    @(negedge clk);
    rstn[1] = 1'b1;
    check("l2_done_rst_ready", {31'b0, m_ready}, 32'h0);
    run_op(1'b0, 32'h40, 4'b1111, 32'h0, 32'hA5A5A5A5, 1'b0, "l2_ld_after_done_rst");

    repeat (3) @(negedge clk);
    check("sb_drain", 32'(sb_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
